ram_multiport: RTL and testbench

- Next-generation register-file RAM. Parametrised depth and width, NUM_RD independent read ports, one byte-enabled write port, a per-entry valid bit, and a single-entry invalidate.
- A sequenced flush engine clears all valid bits.
- Serves as the storage block under parser lookup tables, where entries are filled, queried in parallel and bulk-cleared between messages.

---
 rtl/ram_mp_pkg.sv | 25 ++
 rtl/ram_flush_fsm.sv | 49 ++++
 rtl/ram_multiport.sv | 107 ++++++++++
 tb/tb_ram_multiport.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ram_mp_pkg.sv
// Shared types and helpers for the multi-port register-file RAM.
package ram_mp_pkg;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} flush_state_t;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int be_width_of(input int data_width);
    return data_width / 8;
  endfunction

  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEPTH          = depth_of(DEF_ADDR_WIDTH);
  localparam int BE_WIDTH       = be_width_of(DEF_DATA_WIDTH);

  // Per-byte merge: a byte that is not enabled keeps old data only if the entry held valid data.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b, input logic [7:0] new_b,
                                            input logic be, input logic old_valid);
    return be ? new_b : (old_valid ? old_b : 8'h00);
  endfunction

endpackage

// File: rtl/ram_flush_fsm.sv
// Flush sequencer: sweeps every entry once, clearing one valid bit per cycle.
module ram_flush_fsm
  import ram_mp_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  clr_en_o,
  output logic [ADDR_WIDTH-1:0] clr_idx_o
);

  flush_state_t          state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (flush_i) begin
          state_q <= FLUSH;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
        FLUSH: if (&cnt_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign clr_en_o  = (state_q == FLUSH);
  assign clr_idx_o = cnt_q;

endmodule

// File: rtl/ram_multiport.sv
// Register-file RAM: NUM_RD 1-cycle read ports, one byte-enabled write port,
// per-entry valid bits, single-entry invalidate and a sequenced flush.
module ram_multiport
  import ram_mp_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  output logic                         busy_o,
  input  logic                         write_i,
  input  logic [ADDR_WIDTH-1:0]        write_index_i,
  input  logic [DATA_WIDTH/8-1:0]      write_be_i,
  input  logic [DATA_WIDTH-1:0]        write_data_i,
  input  logic                         invalidate_i,
  input  logic [ADDR_WIDTH-1:0]        invalidate_index_i,
  input  logic [NUM_RD-1:0]            read_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] read_index_i,
  output logic [NUM_RD-1:0]            read_valid_o,
  output logic [NUM_RD-1:0]            read_hit_o,
  output logic [NUM_RD*DATA_WIDTH-1:0] read_value_o
);

  localparam int DEPTH_L = depth_of(ADDR_WIDTH);
  localparam int BE_W    = be_width_of(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_L];
  logic [DEPTH_L-1:0]    valid_q, valid_d;
  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  wr_en, inv_en;
  logic [DATA_WIDTH-1:0] wr_old, wr_merged;
  logic                  wr_old_vld;

  ram_flush_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_flush (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .clr_en_o (clr_en),
    .clr_idx_o(clr_idx)
  );

  // All host traffic is dropped while the sweep owns the array.
  assign wr_en      = write_i & ~busy_o;
  assign inv_en     = invalidate_i & ~busy_o;
  assign wr_old     = mem_q[write_index_i];
  assign wr_old_vld = valid_q[write_index_i];

  for (genvar b = 0; b < BE_W; b++) begin : g_merge
    assign wr_merged[8*b +: 8] = merge_byte(wr_old[8*b +: 8], write_data_i[8*b +: 8],
                                            write_be_i[b], wr_old_vld);
  end

  // Write is applied after invalidate so a same-index collision leaves the entry valid.
  always_comb begin
    valid_d = valid_q;
    if (clr_en) begin
      valid_d[clr_idx] = 1'b0;
    end else begin
      if (inv_en) valid_d[invalidate_index_i] = 1'b0;
      if (wr_en)  valid_d[write_index_i]      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[write_index_i] <= wr_merged;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] idx;
    logic                  fwd, rd_en;
    logic                  vld_q, hit_q;
    logic [DATA_WIDTH-1:0] val_q;

    assign idx   = read_index_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_en = read_i[p] & ~busy_o;
    assign fwd   = wr_en && (idx == write_index_i);

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        hit_q <= 1'b0;
        val_q <= '0;
      end else begin
        vld_q <= rd_en;
        if (rd_en) begin
          hit_q <= fwd | valid_q[idx];
          val_q <= fwd ? wr_merged : (valid_q[idx] ? mem_q[idx] : '0);
        end
      end
    end

    assign read_valid_o[p]                      = vld_q;
    assign read_hit_o[p]                        = hit_q;
    assign read_value_o[p*DATA_WIDTH +: DATA_WIDTH] = val_q;
  end

endmodule

// File: tb/tb_ram_multiport.sv
// Directed self-checking bench for ram_multiport (256-bit, 32 entries, 2 read ports).
module tb_ram_multiport;

  localparam int DW = 256;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i;
  logic            busy_o;
  logic            write_i;
  logic [AW-1:0]   write_index_i;
  logic [DW/8-1:0] write_be_i;
  logic [DW-1:0]   write_data_i;
  logic            invalidate_i;
  logic [AW-1:0]   invalidate_index_i;
  logic [NR-1:0]   read_i;
  logic [NR*AW-1:0] read_index_i;
  logic [NR-1:0]   read_valid_o;
  logic [NR-1:0]   read_hit_o;
  logic [NR*DW-1:0] read_value_o;

  int total = 0;
  int bad   = 0;

  ram_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .busy_o(busy_o),
    .write_i(write_i), .write_index_i(write_index_i), .write_be_i(write_be_i),
    .write_data_i(write_data_i), .invalidate_i(invalidate_i),
    .invalidate_index_i(invalidate_index_i), .read_i(read_i),
    .read_index_i(read_index_i), .read_valid_o(read_valid_o),
    .read_hit_o(read_hit_o), .read_value_o(read_value_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i = 0; write_i = 0; write_index_i = '0; write_be_i = '0; write_data_i = '0;
    invalidate_i = 0; invalidate_index_i = '0; read_i = '0; read_index_i = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] idx, input logic [DW/8-1:0] be,
                          input logic [DW-1:0] data);
    write_i = 1; write_index_i = idx; write_be_i = be; write_data_i = data;
    tick();
    write_i = 0;
  endtask

  task automatic do_read(input logic [AW-1:0] i0, input logic [AW-1:0] i1);
    read_i = 2'b11; read_index_i = {i1, i0};
    tick();
    read_i = '0;
  endtask

  logic [DW-1:0] a5, ones, pat11, pat22, pat33;
  int            nbusy;

  initial begin
    a5 = {32{8'hA5}}; ones = {32{8'hFF}}; pat11 = {32{8'h11}};
    pat22 = {32{8'h22}}; pat33 = {32{8'h33}};
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_busy", DW'(busy_o), '0);
    chk("rst_valid", DW'(read_valid_o), '0);
    chk("rst_hit", DW'(read_hit_o), '0);
    chk("rst_value", read_value_o[DW-1:0], '0);

    // read of invalid entry on port 0 only
    read_i = 2'b01; read_index_i = {5'd0, 5'd3};
    tick();
    read_i = '0;
    chk("inv_rd_valid", DW'(read_valid_o), DW'(2'b01));
    chk("inv_rd_hit", DW'(read_hit_o), '0);
    chk("inv_rd_value", read_value_o[DW-1:0], '0);
    tick();
    chk("rd_valid_drop", DW'(read_valid_o), '0);

    // full write, both ports read same index
    do_write(5'd5, '1, a5);
    do_read(5'd5, 5'd5);
    chk("w5_valid", DW'(read_valid_o), DW'(2'b11));
    chk("w5_hit", DW'(read_hit_o), DW'(2'b11));
    chk("w5_p0", read_value_o[DW-1:0], a5);
    chk("w5_p1", read_value_o[2*DW-1:DW], a5);

    // partial writes: invalid entry zero-fills, valid entry keeps old bytes
    do_write(5'd7, 32'h1, ones);
    do_read(5'd7, 5'd5);
    chk("w7_be1", read_value_o[DW-1:0], DW'(256'hFF));
    chk("w7_p1_other", read_value_o[2*DW-1:DW], a5);
    do_write(5'd7, 32'h2, {32{8'hEE}});
    do_read(5'd7, 5'd7);
    chk("w7_be2", read_value_o[DW-1:0], DW'(256'hEEFF));
    chk("w7_be2_hit", DW'(read_hit_o), DW'(2'b11));

    // read-during-write is write-first
    write_i = 1; write_index_i = 5'd2; write_be_i = '1; write_data_i = pat11;
    read_i = 2'b01; read_index_i = {5'd0, 5'd2};
    tick();
    idle_inputs();
    chk("rdw_hit", DW'(read_hit_o[0]), DW'(1'b1));
    chk("rdw_value", read_value_o[DW-1:0], pat11);

    // write and invalidate same index: write wins
    write_i = 1; write_index_i = 5'd2; write_be_i = '1; write_data_i = pat22;
    invalidate_i = 1; invalidate_index_i = 5'd2;
    tick();
    idle_inputs();
    do_read(5'd2, 5'd2);
    chk("winv_hit", DW'(read_hit_o), DW'(2'b11));
    chk("winv_value", read_value_o[DW-1:0], pat22);

    // invalidate: same-cycle read sees old state, later read misses
    invalidate_i = 1; invalidate_index_i = 5'd5;
    read_i = 2'b10; read_index_i = {5'd5, 5'd0};
    tick();
    idle_inputs();
    chk("inv_same_hit", DW'(read_hit_o[1]), DW'(1'b1));
    chk("inv_same_val", read_value_o[2*DW-1:DW], a5);
    do_read(5'd0, 5'd5);
    chk("inv_after_hit", DW'(read_hit_o[1]), '0);
    chk("inv_after_val", read_value_o[2*DW-1:DW], '0);

    // fill, then flush
    for (int i = 0; i < 32; i++) do_write(AW'(i), '1, {32{8'(i + 1)}});
    do_read(5'd31, 5'd0);
    chk("fill_hit", DW'(read_hit_o), DW'(2'b11));
    chk("fill_val31", read_value_o[DW-1:0], {32{8'd32}});
    flush_i = 1;
    tick();
    flush_i = 0;
    nbusy = 0;
    while (busy_o && nbusy < 40) begin
      nbusy++;
      if (nbusy == 5) begin
        write_i = 1; write_index_i = 5'd0; write_be_i = '1; write_data_i = pat33;
        read_i = 2'b11; read_index_i = {5'd1, 5'd0};
      end else if (nbusy == 6) begin
        chk("flush_rd_ignored", DW'(read_valid_o), '0);
        idle_inputs();
      end
      tick();
    end
    chk("flush_busy_cycles", DW'(nbusy), DW'(32));
    for (int i = 0; i < 32; i++) begin
      do_read(AW'(i), AW'(31 - i));
      chk($sformatf("flushed_%0d", i), DW'({read_valid_o, read_hit_o}), DW'(4'b1100));
    end

    // reset mid-sweep aborts it and still leaves everything invalid
    do_write(5'd20, '1, pat11);
    flush_i = 1;
    tick();
    flush_i = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("abort_busy_before", DW'(busy_o), DW'(1'b1));
    rst = 1;
    tick();
    rst = 0;
    chk("abort_busy", DW'(busy_o), '0);
    do_read(5'd20, 5'd30);
    chk("abort_hit", DW'({read_valid_o, read_hit_o}), DW'(4'b1100));
    do_write(5'd4, '1, pat33);
    chk("abort_busy_idle", DW'(busy_o), '0);
    do_read(5'd4, 5'd4);
    chk("post_abort_hit", DW'(read_hit_o), DW'(2'b11));
    chk("post_abort_val", read_value_o[2*DW-1:DW], pat33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
